// File: rtl/div_pkg.sv
// Shared constants, encodings and decode helpers for the iterative divider.
package div_pkg;

   localparam int unsigned DIV_XLEN = 32;
   localparam int unsigned ITER_N   = 32;
   localparam int unsigned CNT_W    = $clog2(ITER_N);

   typedef enum logic [2:0] {
      F3_DIV  = 3'b100,
      F3_DIVU = 3'b101,
      F3_REM  = 3'b110,
      F3_REMU = 3'b111
   } funct3_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Signed variants operate on two's-complement magnitudes.
   function automatic logic f3_signed(input logic [2:0] f3);
      return (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

   // Remainder variants return the remainder instead of the quotient.
   function automatic logic f3_rem(input logic [2:0] f3);
      return (f3 == F3_REM) || (f3 == F3_REMU);
   endfunction

endpackage

// File: rtl/div_core.sv
// Restoring shift-subtract datapath: one quotient bit per step on unsigned magnitudes.
module div_core
   import div_pkg::*;
#(
   parameter int unsigned XLEN = DIV_XLEN
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic            step,
   input  logic [XLEN-1:0] a_mag,
   input  logic [XLEN-1:0] b_mag,
   output logic [XLEN-1:0] quo_nxt,
   output logic [XLEN-1:0] rem_nxt
);

   logic [XLEN-1:0] rem_q;
   logic [XLEN-1:0] quo_q;
   logic [XLEN-1:0] dvs_q;
   logic [XLEN:0]   shifted;
   logic [XLEN:0]   diff;

   // Partial remainder, dividend/quotient shift register and divisor.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
      end else if (load) begin
         rem_q <= '0;
         quo_q <= a_mag;
         dvs_q <= b_mag;
      end else if (step) begin
         rem_q <= rem_nxt;
         quo_q <= quo_nxt;
      end
   end

   // Trial subtract; the sign of the 33-bit difference selects restore or keep.
   always_comb begin
      shifted = {rem_q, quo_q[XLEN-1]};
      diff    = shifted - {1'b0, dvs_q};
      if (!diff[XLEN]) begin
         rem_nxt = diff[XLEN-1:0];
         quo_nxt = {quo_q[XLEN-2:0], 1'b1};
      end else begin
         rem_nxt = shifted[XLEN-1:0];
         quo_nxt = {quo_q[XLEN-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU/REM/REMU unit for the Execute stage: FSM, iteration
// counter, sign fix-up and special-case results around div_core.
// Optional macro DIV_EARLY_OUT_EN: divisor 0, signed overflow and dividend 0
// bypass the iteration and complete one cycle after start.
module div_sequencer
   import div_pkg::*;
#(
   parameter int unsigned XLEN = DIV_XLEN
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_E,
   input  logic [2:0]      funct3_E,
   input  logic [XLEN-1:0] op_a_E,
   input  logic [XLEN-1:0] op_b_E,
   input  logic            flush_E,
   output logic            stall_req,
   output logic            result_valid,
   output logic [XLEN-1:0] result
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_N - 1);
   localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

   state_e          state;
   state_e          state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [2:0]      f3_q;
   logic [XLEN-1:0] a_q;
   logic [XLEN-1:0] b_q;
   logic [XLEN-1:0] result_q;
   logic            core_load;
   logic            core_step;
   logic            res_load;
   logic [XLEN-1:0] res_nxt;
   logic [XLEN-1:0] a_mag;
   logic [XLEN-1:0] b_mag;
   logic [XLEN-1:0] quo_nxt;
   logic [XLEN-1:0] rem_nxt;

   // Absolute value for signed ops; 0x80000000 maps to 2^31 as unsigned.
   function automatic logic [XLEN-1:0] magnitude(input logic sgn, input logic [XLEN-1:0] x);
      return (sgn && x[XLEN-1]) ? -x : x;
   endfunction

   // Final result from unsigned quotient/remainder magnitudes and the original operands.
   function automatic logic [XLEN-1:0] fix_result(input logic [2:0]      f3,
                                                   input logic [XLEN-1:0] a,
                                                   input logic [XLEN-1:0] b,
                                                   input logic [XLEN-1:0] q_mag,
                                                   input logic [XLEN-1:0] r_mag);
      logic            sgn;
      logic [XLEN-1:0] q;
      logic [XLEN-1:0] r;
      sgn = f3_signed(f3);
      if (b == '0) begin
         q = '1;
         r = a;
      end else if (sgn && (a == MIN_NEG) && (b == '1)) begin
         q = MIN_NEG;
         r = '0;
      end else begin
         q = (sgn && (a[XLEN-1] ^ b[XLEN-1])) ? -q_mag : q_mag;
         r = (sgn && a[XLEN-1]) ? -r_mag : r_mag;
      end
      return f3_rem(f3) ? r : q;
   endfunction

`ifdef DIV_EARLY_OUT_EN
   // Operand patterns whose result is known without iterating.
   function automatic logic early_out(input logic [2:0]      f3,
                                      input logic [XLEN-1:0] a,
                                      input logic [XLEN-1:0] b);
      return (b == '0) || (a == '0) ||
             (f3_signed(f3) && (a == MIN_NEG) && (b == '1));
   endfunction
`endif

   assign a_mag  = magnitude(f3_signed(funct3_E), op_a_E);
   assign b_mag  = magnitude(f3_signed(funct3_E), op_b_E);
   assign result = result_q;

   div_core #(
      .XLEN (XLEN)
   ) u_core (
      .clk     (clk),
      .rst     (rst),
      .load    (core_load),
      .step    (core_step),
      .a_mag   (a_mag),
      .b_mag   (b_mag),
      .quo_nxt (quo_nxt),
      .rem_nxt (rem_nxt)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Latched operation, iteration counter and held result.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt      <= '0;
         f3_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
      end else begin
         if (core_load) begin
            f3_q <= funct3_E;
            a_q  <= op_a_E;
            b_q  <= op_b_E;
            cnt  <= '0;
         end else if (core_step) begin
            cnt  <= cnt + CNT_W'(1);
         end
         if (res_load) begin
            result_q <= res_nxt;
         end
      end
   end

   // Next state, datapath controls, pipeline stall and result strobe.
   always_comb begin
      state_nxt    = state;
      core_load    = 1'b0;
      core_step    = 1'b0;
      res_load     = 1'b0;
      res_nxt      = result_q;
      stall_req    = 1'b0;
      result_valid = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start_E && !flush_E) begin
               stall_req = 1'b1;
               core_load = 1'b1;
`ifdef DIV_EARLY_OUT_EN
               if (early_out(funct3_E, op_a_E, op_b_E)) begin
                  state_nxt = ST_DONE;
                  res_load  = 1'b1;
                  res_nxt   = fix_result(funct3_E, op_a_E, op_b_E, a_mag, '0);
               end else begin
                  state_nxt = ST_BUSY;
               end
`else
               state_nxt = ST_BUSY;
`endif
            end
         end
         ST_BUSY: begin
            stall_req = 1'b1;
            if (flush_E) begin
               state_nxt = ST_IDLE;
            end else begin
               core_step = 1'b1;
               if (cnt == CNT_LAST) begin
                  state_nxt = ST_DONE;
                  res_load  = 1'b1;
                  res_nxt   = fix_result(f3_q, a_q, b_q, quo_nxt, rem_nxt);
               end
            end
         end
         ST_DONE: begin
            result_valid = !flush_E;
            state_nxt    = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_div_sequencer.sv
// Randomized scoreboard bench for div_sequencer against an arithmetic reference.
module tb_div_sequencer;

   localparam int unsigned LAT_FULL = 33;
   localparam int unsigned MAX_WAIT = 100;
`ifdef DIV_EARLY_OUT_EN
   localparam bit EARLY_EN = 1'b1;
`else
   localparam bit EARLY_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        start_E;
   logic        flush_E;
   logic [2:0]  funct3_E;
   logic [31:0] op_a_E;
   logic [31:0] op_b_E;
   logic        stall_req;
   logic        result_valid;
   logic [31:0] result;

   int unsigned cyc = 0;
   int          checks = 0;
   int          passed = 0;
   logic [31:0] exp_q[$];
   int unsigned exp_cyc_q[$];
   logic [31:0] last_exp = '0;
   logic [31:0] mon_e;
   int unsigned mon_c;

   div_sequencer #(.XLEN(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .start_E      (start_E),
      .funct3_E     (funct3_E),
      .op_a_E       (op_a_E),
      .op_b_E       (op_b_E),
      .flush_E      (flush_E),
      .stall_req    (stall_req),
      .result_valid (result_valid),
      .result       (result)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passed++;
      else $display("FAIL %s: got 0x%08h required 0x%08h at cycle %0d", name, act, req, cyc);
   endtask

   // Reference: plain integer division, truncating toward zero for signed ops.
   function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      longint      sa;
      longint      sb;
      logic [31:0] q;
      logic [31:0] r;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (f3[0] == 1'b0) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = 32'(sa / sb);
         r  = 32'(sa % sb);
      end else begin
         q = a / b;
         r = a % b;
      end
      return f3[1] ? r : q;
   endfunction

   function automatic bit early_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      return EARLY_EN && ((b == 32'd0) || (a == 32'd0) ||
             (!f3[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(1, 20));
         4:       return -32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           output int unsigned n);
      @(negedge clk);
      start_E  = 1'b1;
      flush_E  = 1'b0;
      funct3_E = f3;
      op_a_E   = a;
      op_b_E   = b;
      n        = cyc;
   endtask

   // Counts cycles with stall_req high, starting at the issue cycle.
   task automatic wait_retire(output int unsigned k);
      #1;
      k = 0;
      while (stall_req && k < MAX_WAIT) begin
         @(negedge clk);
         #1;
         k++;
      end
   endtask

   task automatic issue(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] expv);
      int unsigned n;
      int unsigned k;
      int unsigned lat;
      start_op(f3, a, b, n);
      lat = early_ref(f3, a, b) ? 1 : LAT_FULL;
      exp_q.push_back(expv);
      exp_cyc_q.push_back(n + lat);
      wait_retire(k);
      check({name, "_stall_len"}, 32'(k), 32'(lat));
   endtask

   task automatic idle(input int unsigned n);
      repeat (n) begin
         @(negedge clk);
         start_E = 1'b0;
         flush_E = 1'b0;
      end
   endtask

   // Monitor: every valid result pops the scoreboard; otherwise result must hold.
   always begin
      @(negedge clk);
      #2;
      if (result_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_valid: result_valid 1 required 0 at cycle %0d", cyc);
         end else begin
            mon_e = exp_q.pop_front();
            mon_c = exp_cyc_q.pop_front();
            check("result", result, mon_e);
            check("valid_cycle", cyc, mon_c);
            last_exp = mon_e;
         end
      end else begin
         check("result_hold", result, last_exp);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned n;
      int unsigned k;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;

      rst      = 1'b0;
      start_E  = 1'b0;
      flush_E  = 1'b0;
      funct3_E = 3'b100;
      op_a_E   = '0;
      op_b_E   = '0;
      repeat (2) @(negedge clk);
      #1;
      check("reset_stall", 32'(stall_req), 32'd0);
      check("reset_valid", 32'(result_valid), 32'd0);
      check("reset_result", result, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      issue("div_100_7", 3'b100, 32'd100, 32'd7, 32'd14);
      idle(1);
      issue("rem_100_7", 3'b110, 32'd100, 32'd7, 32'd2);
      issue("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
      issue("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
      issue("divu_5_0", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF);
      issue("remu_5_0", 3'b111, 32'd5, 32'd0, 32'd5);
      issue("div_m5_0", 3'b100, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF);
      issue("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
      issue("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
      issue("div_0_9", 3'b100, 32'd0, 32'd9, 32'd0);
      idle(2);

      // Flush in the 10th BUSY cycle abandons the op.
      start_op(3'b100, 32'd1000, 32'd7, n);
      repeat (10) @(negedge clk);
      flush_E = 1'b1;
      #1;
      check("flush_busy_stall_hi", 32'(stall_req), 32'd1);
      @(negedge clk);
      flush_E = 1'b0;
      start_E = 1'b0;
      #1;
      check("flush_stall_lo", 32'(stall_req), 32'd0);
      check("flush_valid_lo", 32'(result_valid), 32'd0);
      idle(3);
      issue("after_flush", 3'b111, 32'd1000, 32'd7, 32'd6);
      idle(1);

      // Flush in DONE suppresses the strobe; the result register still updates.
      start_op(3'b101, 32'd1000, 32'd7, n);
      wait_retire(k);
      check("flush_done_stall_len", 32'(k), 32'(LAT_FULL));
      flush_E  = 1'b1;
      last_exp = 32'd142;
      #1;
      check("flush_done_valid", 32'(result_valid), 32'd0);
      idle(3);

      // Reset in the 5th BUSY cycle, then back-to-back ops after release.
      start_op(3'b100, 32'd1000, 32'd3, n);
      repeat (5) @(negedge clk);
      #3;
      rst      = 1'b0;
      start_E  = 1'b0;
      last_exp = 32'd0;
      #1;
      check("rst_mid_stall", 32'(stall_req), 32'd0);
      check("rst_mid_valid", 32'(result_valid), 32'd0);
      check("rst_mid_result", result, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      issue("b2b_div", 3'b100, 32'd1000, 32'd3, 32'd333);
      issue("b2b_rem", 3'b110, 32'hFFFF_FC18, 32'd3, 32'hFFFF_FFFF);
      issue("b2b_divu", 3'b101, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF);

      for (int i = 0; i < 40; i++) begin
         f3 = {1'b1, 2'($urandom_range(0, 3))};
         a  = pick_operand();
         b  = pick_operand();
         issue("rand", f3, a, b, ref_res(f3, a, b));
         if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
      end

      idle(5);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
